// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/adjust sequencer keeping MM:SS as four BCD digits.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_MIN     = 59,
   parameter int MAX_SEC     = 59
) (
   input  logic       CLK_REF,
   input  logic       CLK_RES,
   input  logic       TICK_1HZ,
   input  logic       TICK_2HZ,
   input  logic       TICK_BLINK,
   input  logic       BTN_PAUSE,
   input  logic       BTN_RST,
   input  logic       BTN_LAP,
   input  logic       SW_ADJ,
   input  logic       SW_SEL,
   output logic [3:0] MIN_TENS,
   output logic [3:0] MIN_ONES,
   output logic [3:0] SEC_TENS,
   output logic [3:0] SEC_ONES,
   output logic [1:0] BLANK,
   output logic [1:0] STATE,
   output logic       LAP_ACTIVE
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_ADJ   = 2'b11
   } state_e;

   localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [7:0] SEC_MAX = {4'(MAX_SEC / 10), 4'(MAX_SEC % 10)};
   localparam logic [7:0] MIN_MAX = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

   // Packed BCD {tens, ones}; bit 8 of the result flags the wrap to 00.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v,
                                          input logic [7:0] mx);
      logic [8:0] r;
      r = {1'b0, v[7:4], v[3:0] + 4'd1};
      if (v[3:0] == 4'd9) begin
         r = {1'b0, v[7:4] + 4'd1, 4'd0};
      end
      if (v == mx) begin
         r = 9'h100;
      end
      return r;
   endfunction

   logic [4:0] async_in;
   logic [4:0] sync_q [NSYNC];
   logic [2:0] btn_prev_q;
   logic [2:0] btn_ev_q;
   logic [1:0] sw_q;
   logic       t1_prev_q;
   logic       t2_prev_q;
   logic       t1_ev_q;
   logic       t2_ev_q;

   state_e     state_q;
   state_e     state_d;
   logic [7:0] sec_q;
   logic [7:0] sec_d;
   logic [7:0] min_q;
   logic [7:0] min_d;
   logic [8:0] sec_inc;
   logic [8:0] min_inc;
   logic [7:0] disp_sec;
   logic [7:0] disp_min;

   logic pause_ev;
   logic rst_ev;
   logic lap_ev;
   logic adj_lvl;
   logic sel_lvl;

   assign async_in = {SW_SEL, SW_ADJ, BTN_LAP, BTN_RST, BTN_PAUSE};

   assign pause_ev = btn_ev_q[0];
   assign rst_ev   = btn_ev_q[1];
   assign lap_ev   = btn_ev_q[2];
   assign adj_lvl  = sw_q[0];
   assign sel_lvl  = sw_q[1];

   // Edge pulses are registered so every control input sees equal latency.
   always_ff @(posedge CLK_REF or posedge CLK_RES) begin
      if (CLK_RES) begin
         for (int i = 0; i < NSYNC; i++) begin
            sync_q[i] <= '0;
         end
         btn_prev_q <= '0;
         btn_ev_q   <= '0;
         sw_q       <= '0;
         t1_prev_q  <= 1'b0;
         t2_prev_q  <= 1'b0;
         t1_ev_q    <= 1'b0;
         t2_ev_q    <= 1'b0;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < NSYNC; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         btn_prev_q <= sync_q[NSYNC-1][2:0];
         btn_ev_q   <= sync_q[NSYNC-1][2:0] & ~btn_prev_q;
         sw_q       <= sync_q[NSYNC-1][4:3];
         t1_prev_q  <= TICK_1HZ;
         t2_prev_q  <= TICK_2HZ;
         t1_ev_q    <= TICK_1HZ & ~t1_prev_q;
         t2_ev_q    <= TICK_2HZ & ~t2_prev_q;
      end
   end

   always_ff @(posedge CLK_REF or posedge CLK_RES) begin
      if (CLK_RES) begin
         state_q <= S_IDLE;
         sec_q   <= '0;
         min_q   <= '0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
      end
   end

   assign sec_inc = bcd_inc(sec_q, SEC_MAX);
   assign min_inc = bcd_inc(min_q, MIN_MAX);

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      min_d   = min_q;
      if (adj_lvl) begin
         // The entry cycle itself discards any pending tick or clear.
         state_d = S_ADJ;
         if (state_q == S_ADJ) begin
            if (rst_ev) begin
               sec_d = '0;
               min_d = '0;
            end else if (t2_ev_q) begin
               if (sel_lvl) begin
                  min_d = min_inc[7:0];
               end else begin
                  sec_d = sec_inc[7:0];
               end
            end
         end
      end else if (state_q == S_ADJ) begin
         state_d = S_PAUSE;
      end else if (rst_ev) begin
         state_d = S_IDLE;
         sec_d   = '0;
         min_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pause_ev) state_d = S_RUN;
            end
            S_RUN: begin
               if (t1_ev_q) begin
                  sec_d = sec_inc[7:0];
                  if (sec_inc[8]) min_d = min_inc[7:0];
               end
               if (pause_ev) state_d = S_PAUSE;
            end
            S_PAUSE: begin
               if (pause_ev) state_d = S_RUN;
            end
            S_ADJ: begin
               state_d = S_PAUSE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      STATE = state_q;
      BLANK = 2'b00;
      if (state_q == S_ADJ) begin
         if (sel_lvl) begin
            BLANK = {TICK_BLINK, 1'b0};
         end else begin
            BLANK = {1'b0, TICK_BLINK};
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic       lap_q;
   logic       lap_d;
   logic [7:0] lap_sec_q;
   logic [7:0] lap_sec_d;
   logic [7:0] lap_min_q;
   logic [7:0] lap_min_d;

   always_comb begin
      lap_d     = lap_q;
      lap_sec_d = lap_sec_q;
      lap_min_d = lap_min_q;
      if (state_d != S_RUN) begin
         lap_d = 1'b0;
      end else if (state_q == S_RUN && lap_ev) begin
         lap_d = ~lap_q;
         if (!lap_q) begin
            lap_sec_d = sec_d;
            lap_min_d = min_d;
         end
      end
   end

   always_ff @(posedge CLK_REF or posedge CLK_RES) begin
      if (CLK_RES) begin
         lap_q     <= 1'b0;
         lap_sec_q <= '0;
         lap_min_q <= '0;
      end else begin
         lap_q     <= lap_d;
         lap_sec_q <= lap_sec_d;
         lap_min_q <= lap_min_d;
      end
   end

   assign LAP_ACTIVE = lap_q;
   assign disp_sec   = lap_q ? lap_sec_q : sec_q;
   assign disp_min   = lap_q ? lap_min_q : min_q;
`else
   logic unused_lap;
   assign unused_lap = lap_ev;
   assign LAP_ACTIVE = 1'b0;
   assign disp_sec   = sec_q;
   assign disp_min   = min_q;
`endif

   assign {MIN_TENS, MIN_ONES} = disp_min;
   assign {SEC_TENS, SEC_ONES} = disp_sec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed test-plan sequences plus random stimulus,
// checked every cycle against a latency-aware MM:SS reference model.
module tb_stopwatch_ctrl;

   localparam int SYNC = 2;
   localparam int D    = SYNC + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic t1 = 1'b0, t2 = 1'b0, blink = 1'b0;
   logic b_pause = 1'b0, b_rst = 1'b0, b_lap = 1'b0;
   logic sw_adj = 1'b0, sw_sel = 1'b0;

   logic [3:0] min_t, min_o, sec_t, sec_o;
   logic [1:0] blank, state;
   logic       lap_act;

   stopwatch_ctrl #(
      .SYNC_STAGES(SYNC),
      .MAX_MIN(59),
      .MAX_SEC(59)
   ) dut (
      .CLK_REF(clk),
      .CLK_RES(rst),
      .TICK_1HZ(t1),
      .TICK_2HZ(t2),
      .TICK_BLINK(blink),
      .BTN_PAUSE(b_pause),
      .BTN_RST(b_rst),
      .BTN_LAP(b_lap),
      .SW_ADJ(sw_adj),
      .SW_SEL(sw_sel),
      .MIN_TENS(min_t),
      .MIN_ONES(min_o),
      .SEC_TENS(sec_t),
      .SEC_ONES(sec_o),
      .BLANK(blank),
      .STATE(state),
      .LAP_ACTIVE(lap_act)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic pause;
      logic brst;
      logic lap;
      logic adj;
      logic sel;
      logic t1;
      logic t2;
   } samp_t;

   samp_t h[$];
   int    m_st, m_m, m_s;
   int    m_lap, m_lm, m_ls;
   int    checks = 0;
   int    failures = 0;
   bit    chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic logic [15:0] bcd4(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic mreset();
      h.delete();
      repeat (8) h.push_back('0);
      m_st = 0; m_m = 0; m_s = 0;
      m_lap = 0; m_lm = 0; m_ls = 0;
   endtask

   // Controls act SYNC+1 edges after first sampling; ticks act one edge later.
   task automatic mstep();
      samp_t cur;
      bit    pe, re, adj, sel, e1, e2;
      int    ns, tot;
      cur = {b_pause, b_rst, b_lap, sw_adj, sw_sel, t1, t2};
      h.push_front(cur);
      void'(h.pop_back());
      pe  = h[D].pause && !h[D+1].pause;
      re  = h[D].brst && !h[D+1].brst;
      adj = h[D].adj;
      sel = h[D].sel;
      e1  = h[1].t1 && !h[2].t1;
      e2  = h[1].t2 && !h[2].t2;
      ns  = m_st;
      if (adj) begin
         ns = 3;
         if (m_st == 3) begin
            if (re) begin
               m_m = 0; m_s = 0;
            end else if (e2) begin
               if (sel) m_m = (m_m + 1) % 60;
               else     m_s = (m_s + 1) % 60;
            end
         end
      end else if (m_st == 3) begin
         ns = 2;
      end else if (re) begin
         ns = 0; m_m = 0; m_s = 0;
      end else begin
         case (m_st)
            0: if (pe) ns = 1;
            1: begin
               if (e1) begin
                  tot = (m_m * 60 + m_s + 1) % 3600;
                  m_m = tot / 60;
                  m_s = tot % 60;
               end
               if (pe) ns = 2;
            end
            2: if (pe) ns = 1;
            default: ns = 0;
         endcase
      end
`ifdef STOPWATCH_LAP_EN
      begin
         bit le;
         le = h[D].lap && !h[D+1].lap;
         if (ns != 1) m_lap = 0;
         else if (m_st == 1 && le) begin
            if (m_lap == 0) begin
               m_lm = m_m; m_ls = m_s;
            end
            m_lap = (m_lap == 0) ? 1 : 0;
         end
      end
`endif
      m_st = ns;
   endtask

   task automatic mcheck();
      int dm, ds;
      logic [1:0] eb;
      dm = (m_lap != 0) ? m_lm : m_m;
      ds = (m_lap != 0) ? m_ls : m_s;
      eb = 2'b00;
      if (m_st == 3) eb = h[SYNC].sel ? {blink, 1'b0} : {1'b0, blink};
      chk("digits", {min_t, min_o, sec_t, sec_o}, bcd4(dm, ds));
      chk("state", state, m_st);
      chk("blank", blank, eb);
      chk("lap_active", lap_act, m_lap);
   endtask

   always @(posedge clk) begin
      if (rst) mreset();
      else     mstep();
      #2;
      if (!rst && chk_en) mcheck();
   end

   task automatic setb(input int w, input logic v);
      case (w)
         0: b_pause = v;
         1: b_rst   = v;
         default: b_lap = v;
      endcase
   endtask

   task automatic press(input int w);
      setb(w, 1'b1);
      repeat (2) @(negedge clk);
      setb(w, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic tick1(input int n);
      for (int i = 0; i < n; i++) begin
         t1 = 1'b1;
         repeat (2) @(negedge clk);
         t1 = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic tick2(input int n);
      for (int i = 0; i < n; i++) begin
         t2 = 1'b1;
         blink = 1'($urandom_range(0, 1));
         repeat (2) @(negedge clk);
         t2 = 1'b0;
         blink = 1'($urandom_range(0, 1));
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      repeat (10) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_state", state, 2'b00);
      chk("rst_digits", {min_t, min_o, sec_t, sec_o}, 16'h0000);
      chk("rst_blank", blank, 2'b00);

      press(0);
      chk("start_run", state, 2'b01);
      tick1(61);
      chk("run_61", {min_t, min_o, sec_t, sec_o}, 16'h0101);

      sw_adj = 1'b1;
      wait_n(6);
      chk("enter_adj", state, 2'b11);
      press(1);
      chk("adj_clear", {min_t, min_o, sec_t, sec_o}, 16'h0000);
      chk("adj_stay", state, 2'b11);
      sw_sel = 1'b1;
      wait_n(4);
      tick2(59);
      sw_sel = 1'b0;
      wait_n(4);
      tick2(58);
      chk("preload", {min_t, min_o, sec_t, sec_o}, 16'h5958);
      sw_adj = 1'b0;
      wait_n(6);
      chk("adj_exit", state, 2'b10);
      press(0);
      tick1(1);
      chk("at_5959", {min_t, min_o, sec_t, sec_o}, 16'h5959);
      tick1(1);
      chk("wrap_0000", {min_t, min_o, sec_t, sec_o}, 16'h0000);

      press(1);
      chk("btn_rst_idle", state, 2'b00);
      press(0);
      tick1(5);
      b_pause = 1'b1;
      wait_n(2);
      t1 = 1'b1;
      wait_n(1);
      b_pause = 1'b0;
      wait_n(1);
      t1 = 1'b0;
      wait_n(4);
      chk("simul_time", {min_t, min_o, sec_t, sec_o}, 16'h0006);
      chk("simul_state", state, 2'b10);
      tick1(3);
      chk("pause_hold", {min_t, min_o, sec_t, sec_o}, 16'h0006);

      press(0);
      tick1(24);
      chk("at_0030", {min_t, min_o, sec_t, sec_o}, 16'h0030);
      sw_adj = 1'b1;
      sw_sel = 1'b1;
      wait_n(6);
      tick2(61);
      chk("min_adj", {min_t, min_o, sec_t, sec_o}, 16'h0130);
      blink = 1'b1;
      wait_n(1);
      chk("blank_on", blank, 2'b10);
      blink = 1'b0;
      wait_n(1);
      chk("blank_off", blank, 2'b00);

      press(1);
      wait_n(4);
      tick2(12);
      sw_sel = 1'b0;
      wait_n(4);
      tick2(34);
      sw_adj = 1'b0;
      wait_n(6);
      press(0);
      chk("at_1234", {min_t, min_o, sec_t, sec_o}, 16'h1234);
      chk("run_1234", state, 2'b01);
      rst = 1'b1;
      #1;
      chk("async_digits", {min_t, min_o, sec_t, sec_o}, 16'h0000);
      chk("async_state", state, 2'b00);
      chk("async_flags", {blank, lap_act}, 3'b000);
      wait_n(3);
      rst = 1'b0;
      wait_n(2);

      press(0);
      tick1(10);
      press(2);
      tick1(5);
`ifdef STOPWATCH_LAP_EN
      chk("lap_hold", {min_t, min_o, sec_t, sec_o}, 16'h0010);
      chk("lap_on", lap_act, 1'b1);
`else
      chk("lap_ignored", {min_t, min_o, sec_t, sec_o}, 16'h0015);
      chk("lap_tied", lap_act, 1'b0);
`endif
      press(2);
      chk("lap_release", {min_t, min_o, sec_t, sec_o}, 16'h0015);
      chk("lap_off", lap_act, 1'b0);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) b_pause = ~b_pause;
         if ($urandom_range(0, 199) == 0) b_rst = ~b_rst;
         if ($urandom_range(0, 29) == 0) b_lap = ~b_lap;
         if ($urandom_range(0, 149) == 0) sw_adj = ~sw_adj;
         if ($urandom_range(0, 39) == 0) sw_sel = ~sw_sel;
         if ($urandom_range(0, 3) == 0) t1 = ~t1;
         if ($urandom_range(0, 3) == 0) t2 = ~t2;
         if ($urandom_range(0, 7) == 0) blink = ~blink;
         if ($urandom_range(0, 1499) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller for the stopwatch datapath. It consumes the 1 Hz, 2 Hz and blink outputs of the clock divider block and user button/switch inputs. It runs a run/pause/adjust state machine and keeps the MM:SS time as four BCD digits. It drives the digit values and per-field blanking to the seven-segment display driver.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the button synchronizers (minimum 2)
MAX_MIN, 59, highest minute value before wrap to 00
MAX_SEC, 59, highest second value before wrap to 00

Ports:
CLK_REF  input  1  system reference clock; all state on its rising edge
CLK_RES  input  1  asynchronous, active-high reset
TICK_1HZ  input  1  1 Hz level from the clock divider, synchronous to CLK_REF
TICK_2HZ  input  1  2 Hz level from the clock divider, synchronous to CLK_REF
TICK_BLINK  input  1  blink level from the clock divider, synchronous to CLK_REF
BTN_PAUSE  input  1  pause/resume button, asynchronous level, debounced externally
BTN_RST  input  1  clear button, asynchronous level
BTN_LAP  input  1  lap button, asynchronous level; used only with the optional feature
SW_ADJ  input  1  adjust-mode switch, asynchronous level
SW_SEL  input  1  adjust field select: 0 = seconds, 1 = minutes
MIN_TENS  output  4  BCD minutes tens digit
MIN_ONES  output  4  BCD minutes ones digit
SEC_TENS  output  4  BCD seconds tens digit
SEC_ONES  output  4  BCD seconds ones digit
BLANK  output  2  bit1 = blank minutes field, bit0 = blank seconds field
STATE  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ADJUST
LAP_ACTIVE  output  1  display frozen by lap

Behaviour:
- Clock port is CLK_REF; reset port is CLK_RES, asynchronous, active-high.
- Reset values: all digits 0, BLANK = 00, STATE = IDLE, LAP_ACTIVE = 0, all synchronizer and edge flops 0.
- Asynchronous inputs (BTN_PAUSE, BTN_RST, BTN_LAP, SW_ADJ, SW_SEL) pass through SYNC_STAGES flops.
- Buttons are rising-edge detected after synchronization. SW_ADJ and SW_SEL are used as synchronized levels.
- Button latency: with the input first sampled high at edge k, the state or counter change is visible after edge k+SYNC_STAGES+1.
- TICK_* inputs are not synchronized. TICK_1HZ and TICK_2HZ are rising-edge detected with one previous-value flop, so a count update is visible after the 2nd CLK_REF edge that samples the tick high.
- Each tick edge produces exactly one event, regardless of how long the tick stays high.
- Time counting: SEC_ONES counts 0..9. SEC_TENS counts 0..5. MIN digits follow the same scheme, limited by MAX_MIN and MAX_SEC.
- 59:59 + 1 wraps to 00:00. No overflow flag.
- FSM, in priority order:
  - SW_ADJ=1 forces ADJUST from any state.
  - BTN_RST edge (outside ADJUST) -> IDLE and clears time to 00:00.
  - IDLE: BTN_PAUSE edge -> RUN.
  - RUN: TICK_1HZ edge increments the time with carry. BTN_PAUSE edge -> PAUSE.
  - PAUSE: BTN_PAUSE edge -> RUN. Ticks are ignored.
  - ADJUST: each TICK_2HZ edge increments the selected field only. The field wraps MAX->0 with no carry between fields.
  - ADJUST: BTN_RST clears the time but stays in ADJUST. BTN_PAUSE is ignored.
  - ADJUST: SW_ADJ falling -> PAUSE.
- Simultaneous events:
  - Reset edge and tick in the same cycle: reset wins, result is 00:00.
  - Pause edge and TICK_1HZ edge in the same cycle in RUN: the tick is counted, then the state moves to PAUSE.
  - SW_ADJ rising and a tick in the same cycle: the tick is discarded.
- BLANK: in ADJUST, the selected field's bit = TICK_BLINK and the other bit = 0. Outside ADJUST, BLANK = 00.
- Changing SW_SEL mid-ADJUST takes effect on the next 2 Hz edge.
- CLK_RES asserted mid-operation returns every register to its reset value immediately.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: a BTN_LAP edge in RUN toggles LAP_ACTIVE.
  - While LAP_ACTIVE=1, the digit outputs hold the time captured at the lap edge; the internal count continues.
  - A second lap edge releases the hold and shows the live time on the next cycle.
  - Leaving RUN (pause, reset or adjust) clears LAP_ACTIVE.
- Undefined: BTN_LAP is ignored, LAP_ACTIVE is tied to 0, and the digit outputs always show the live count.
- The port list is identical in both builds.

Test Plan:
- Reset held for 100 ns, then released; one BTN_PAUSE press; 61 TICK_1HZ edges -> STATE=01, display 01:01.
- Preload 59:58 via ADJUST; in RUN, 2 TICK_1HZ edges -> 00:00, no stuck digits.
- In RUN, BTN_PAUSE edge in the same cycle as a TICK_1HZ edge at 00:05 -> 00:06, STATE=10; 3 further ticks -> still 00:06.
- SW_ADJ=1, SW_SEL=1 starting at 00:30; 61 TICK_2HZ edges -> 01:30 (minutes wrap 59->00), seconds unchanged. BLANK = {TICK_BLINK,0} throughout.
- CLK_RES pulse asserted mid-RUN at 12:34 -> all outputs 0 within the same cycle, STATE=00.
- STOPWATCH_LAP_EN defined: lap press at 00:10, then 5 ticks -> display 00:10 and LAP_ACTIVE=1; second lap press -> display 00:15, LAP_ACTIVE=0.
